// File: rtl/fp_wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_wb_pkg
//  Description : Shared types and default parameters for the FP writeback
//                arbiter: the buffered divide/sqrt entry type and the default
//                FIFO depth / starvation limit.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_wb_pkg;

  localparam int FP_WB_ADDR_WIDTH   = 5;
  localparam int FP_WB_DATA_WIDTH   = 32;
  localparam int FP_WB_NUM_REGS     = 32;
  localparam int FP_WB_FIFO_DEPTH   = 2;
  localparam int FP_WB_STARVE_LIMIT = 8;

  // One buffered divide/sqrt result: destination register and value.
  typedef struct packed {
    logic [FP_WB_ADDR_WIDTH-1:0] rd;
    logic [FP_WB_DATA_WIDTH-1:0] data;
  } wb_entry_t;

endpackage : fp_wb_pkg
`default_nettype wire

// File: rtl/fp_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : fp_wb_arbiter_if
//  Description : Bus bundle around the FP writeback arbiter.
//                Inputs to the arbiter : a_valid/a_rd/a_data (pipeline),
//                                        b_valid/b_rd/b_data (divide/sqrt)
//                Outputs of the arbiter: b_ready, fwb_en/rd_idx/fwb_data,
//                                        stall_req, pend_mask
//                modport slave  - seen from the arbiter
//                modport master - seen from the producers / register file
//  Revision    : 1.0 - initial release
// ============================================================================
interface fp_wb_arbiter_if
  import fp_wb_pkg::*;
#(
  parameter int DATA_WIDTH = FP_WB_DATA_WIDTH,
  parameter int ADDR_WIDTH = FP_WB_ADDR_WIDTH,
  parameter int NUM_REGS   = FP_WB_NUM_REGS
);

  logic                  a_valid;
  logic [ADDR_WIDTH-1:0] a_rd;
  logic [DATA_WIDTH-1:0] a_data;
  logic                  b_valid;
  logic                  b_ready;
  logic [ADDR_WIDTH-1:0] b_rd;
  logic [DATA_WIDTH-1:0] b_data;
  logic                  fwb_en;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [DATA_WIDTH-1:0] fwb_data;
  logic                  stall_req;
  logic [NUM_REGS-1:0]   pend_mask;

  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    output b_ready, fwb_en, rd_idx, fwb_data, stall_req, pend_mask
  );

  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    input  b_ready, fwb_en, rd_idx, fwb_data, stall_req, pend_mask
  );

endinterface : fp_wb_arbiter_if
`default_nettype wire

// File: rtl/fp_wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fp_wb_fifo
//  Description : Small wb_entry_t FIFO for divide/sqrt results.
//                clk, rst      : clock, asynchronous active-low reset
//                push/push_entry : write request and entry
//                pop           : read request (ignored when empty)
//                head          : oldest entry
//                count         : number of stored entries
//                entry_valid/entry_rd : per-slot occupancy and destination
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_wb_fifo
  import fp_wb_pkg::*;
#(
  parameter int DEPTH = FP_WB_FIFO_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  wire logic                                    clk,
  input  wire logic                                    rst,
  input  wire logic                                    push,
  input  wire wb_entry_t                               push_entry,
  input  wire logic                                    pop,
  output wb_entry_t                                    head,
  output logic [CNT_W-1:0]                             count,
  output logic [DEPTH-1:0]                             entry_valid,
  output logic [DEPTH-1:0][FP_WB_ADDR_WIDTH-1:0]       entry_rd
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count_q != '0);
  // A push into a full FIFO is legal when the head leaves in the same cycle;
  // both pointers then address the same slot and the head is read before
  // the write lands.
  assign do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    mem_d    = mem_q;
    // Clear before set so a same-slot pop+push leaves the slot valid.
    if (do_pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end
    if (do_push) begin
      valid_d[wr_ptr_q] = 1'b1;
      mem_d[wr_ptr_q]   = push_entry;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      mem_q    <= mem_d;
    end
  end

  assign head        = mem_q[rd_ptr_q];
  assign count       = count_q;
  assign entry_valid = valid_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry_rd
    assign entry_rd[i] = mem_q[i].rd;
  end

endmodule : fp_wb_fifo
`default_nettype wire

// File: rtl/fp_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fp_wb_arbiter
//  Description : Merges the fixed-latency FP pipeline (A, never stalled) and
//                the divide/sqrt unit (B, valid/ready, buffered in a FIFO)
//                into one registered FP register-file write stream.
//                clk  : clock, rising edge
//                rst  : asynchronous active-low reset
//                bus  : fp_wb_arbiter_if.slave - A/B inputs, b_ready,
//                       fwb_en/rd_idx/fwb_data, stall_req, pend_mask
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_wb_arbiter
  import fp_wb_pkg::*;
#(
  parameter int DATA_WIDTH   = FP_WB_DATA_WIDTH,
  parameter int ADDR_WIDTH   = FP_WB_ADDR_WIDTH,
  parameter int NUM_REGS     = FP_WB_NUM_REGS,
  parameter int FIFO_DEPTH   = FP_WB_FIFO_DEPTH,
  parameter int STARVE_LIMIT = FP_WB_STARVE_LIMIT
) (
  input wire logic          clk,
  input wire logic          rst,
  fp_wb_arbiter_if.slave    bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  wb_entry_t                                  push_entry;
  wb_entry_t                                  head;
  logic [CNT_W-1:0]                           count;
  logic [FIFO_DEPTH-1:0]                      entry_valid;
  logic [FIFO_DEPTH-1:0][FP_WB_ADDR_WIDTH-1:0] entry_rd;
  logic                                       b_ready;
  logic                                       push;
  logic                                       pop;
  logic                                       fifo_empty;
  logic [NUM_REGS-1:0]                        pend_mask;

  logic                  fwb_en_q,    fwb_en_d;
  logic [ADDR_WIDTH-1:0] rd_idx_q,    rd_idx_d;
  logic [DATA_WIDTH-1:0] fwb_data_q,  fwb_data_d;
  logic                  stall_req_q, stall_req_d;
  logic [SC_W-1:0]       starve_q,    starve_d;

  // Ready depends only on the registered occupancy, never on a_valid.
  assign b_ready    = (count != CNT_W'(FIFO_DEPTH));
  assign push       = bus.b_valid && b_ready;
  assign fifo_empty = (count == '0);
  // A always wins; the FIFO head takes any slot A leaves free.
  assign pop        = !bus.a_valid && !fifo_empty;
  assign push_entry = '{rd: bus.b_rd, data: bus.b_data};

  fp_wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_entry  (push_entry),
    .pop         (pop),
    .head        (head),
    .count       (count),
    .entry_valid (entry_valid),
    .entry_rd    (entry_rd)
  );

  always_comb begin
    fwb_en_d    = bus.a_valid || pop;
    rd_idx_d    = rd_idx_q;
    fwb_data_d  = fwb_data_q;
    starve_d    = starve_q;
    stall_req_d = 1'b0;

    if (bus.a_valid) begin
      rd_idx_d   = bus.a_rd;
      fwb_data_d = bus.a_data;
    end else if (pop) begin
      rd_idx_d   = head.rd;
      fwb_data_d = head.data;
    end

    if (fifo_empty || pop) begin
      starve_d = '0;
    end else begin
      // Non-empty and A took the slot. Using >= rather than == lets the
      // request re-assert if the issue stage ignores a stall cycle.
      stall_req_d = (starve_q >= SC_W'(STARVE_LIMIT - 1));
      if (starve_q != SC_W'(STARVE_LIMIT)) begin
        starve_d = starve_q + SC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwb_en_q    <= 1'b0;
      rd_idx_q    <= '0;
      fwb_data_q  <= '0;
      stall_req_q <= 1'b0;
      starve_q    <= '0;
    end else begin
      fwb_en_q    <= fwb_en_d;
      rd_idx_q    <= rd_idx_d;
      fwb_data_q  <= fwb_data_d;
      stall_req_q <= stall_req_d;
      starve_q    <= starve_d;
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (entry_valid[i]) begin
        pend_mask[entry_rd[i]] = 1'b1;
      end
    end
  end

  assign bus.b_ready   = b_ready;
  assign bus.fwb_en    = fwb_en_q;
  assign bus.rd_idx    = rd_idx_q;
  assign bus.fwb_data  = fwb_data_q;
  assign bus.stall_req = stall_req_q;
  assign bus.pend_mask = pend_mask;

endmodule : fp_wb_arbiter
`default_nettype wire
